// File: rtl/mul_accumulate_stage_if.sv
// Valid/ready bundle between the array multiplier, the accumulate stage and
// the result consumer. The stage itself uses the slave modport.
interface mul_accumulate_stage_if #(
    parameter int N     = 4,
    parameter int ACC_W = 12
);
    logic             start;
    logic [2*N-1:0]   prod_in;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             ovf;
    logic             busy;

    modport master (
        output start, prod_in, prod_valid, acc_ready,
        input  prod_ready, acc_out, acc_valid, ovf, busy
    );

    modport slave (
        input  start, prod_in, prod_valid, acc_ready,
        output prod_ready, acc_out, acc_valid, ovf, busy
    );
endinterface

// File: rtl/mul_accumulate_stage.sv
// Accumulates LEN unsigned products into an ACC_W-bit sum and offers the
// result on a valid/ready port, with saturating or wrapping overflow.
module mul_accumulate_stage #(
    parameter int N     = 4,
    parameter int ACC_W = 12,
    parameter int LEN   = 8,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mul_accumulate_stage_if.slave bus
);
    localparam int PROD_W = 2 * N;
    localparam int CNT_W  = $clog2(LEN + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum;
    logic               prod_xfer;
    logic               res_xfer;

    assign prod = bus.prod_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The extra sum bit is the carry-out that marks an overflow on this add.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum       = {1'b0, acc_q} + (ACC_W + 1)'(prod);
        prod_xfer = bus.prod_valid && (state_q == ACCUM);
        res_xfer  = bus.acc_ready && (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (prod_xfer) begin
                    if (sum[ACC_W]) begin
                        ovf_d = 1'b1;
                        acc_d = (SAT != 0) ? '1 : sum[ACC_W-1:0];
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    if (cnt_q == CNT_W'(LEN - 1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // A start coinciding with the result handoff chains the next run.
                if (res_xfer) begin
                    if (bus.start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.prod_ready = (state_q == ACCUM);
    assign bus.acc_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.acc_out    = acc_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_mul_accumulate_stage.sv
// Drives three stage instances (12-bit saturating, 10-bit saturating, 10-bit
// wrapping) in lockstep and scores every result against a sum-based model.
module tb_mul_accumulate_stage;
    localparam int N   = 4;
    localparam int LEN = 8;

    typedef struct {
        int a_acc;
        int a_ovf;
        int s_acc;
        int s_ovf;
        int w_acc;
        int w_ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   prod_in = '0;
    logic         prod_valid = 1'b0;
    logic         acc_ready = 1'b0;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    int   prods[LEN];

    always #5 clk = ~clk;

    mul_accumulate_stage_if #(.N(N), .ACC_W(12)) if_a();
    mul_accumulate_stage_if #(.N(N), .ACC_W(10)) if_s();
    mul_accumulate_stage_if #(.N(N), .ACC_W(10)) if_w();

    assign if_a.start = start;  assign if_a.prod_in = prod_in;
    assign if_a.prod_valid = prod_valid;  assign if_a.acc_ready = acc_ready;
    assign if_s.start = start;  assign if_s.prod_in = prod_in;
    assign if_s.prod_valid = prod_valid;  assign if_s.acc_ready = acc_ready;
    assign if_w.start = start;  assign if_w.prod_in = prod_in;
    assign if_w.prod_valid = prod_valid;  assign if_w.acc_ready = acc_ready;

    mul_accumulate_stage #(.N(N), .ACC_W(12), .LEN(LEN), .SAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    mul_accumulate_stage #(.N(N), .ACC_W(10), .LEN(LEN), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(if_s.slave));
    mul_accumulate_stage #(.N(N), .ACC_W(10), .LEN(LEN), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // The result depends only on the true total: clamp or reduce modulo 2^W.
    function automatic exp_t model(input int total);
        exp_t e;
        e.a_acc = (total > 4095) ? 4095 : total;
        e.a_ovf = (total > 4095) ? 1 : 0;
        e.s_acc = (total > 1023) ? 1023 : total;
        e.s_ovf = (total > 1023) ? 1 : 0;
        e.w_acc = total % 1024;
        e.w_ovf = (total > 1023) ? 1 : 0;
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && if_a.acc_valid && acc_ready) begin
                checkOutput("sb_has_entry", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    checkOutput("res_acc12", if_a.acc_out, e.a_acc);
                    checkOutput("res_ovf12", if_a.ovf, e.a_ovf);
                    checkOutput("res_valid_sat10", if_s.acc_valid, 1);
                    checkOutput("res_acc_sat10", if_s.acc_out, e.s_acc);
                    checkOutput("res_ovf_sat10", if_s.ovf, e.s_ovf);
                    checkOutput("res_valid_wrap10", if_w.acc_valid, 1);
                    checkOutput("res_acc_wrap10", if_w.acc_out, e.w_acc);
                    checkOutput("res_ovf_wrap10", if_w.ovf, e.w_ovf);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (if_a.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k == 200) checkOutput("wait_idle_timeout", if_a.busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_product(input int p, input int gap);
        int k = 0;
        prod_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        prod_in    = p[7:0];
        prod_valid = 1'b1;
        @(negedge clk);
        while (!if_a.prod_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) checkOutput("prod_ready_timeout", if_a.prod_ready, 1);
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
    endtask

    task automatic collect_result(input int delay);
        int k = 0;
        @(negedge clk);
        while (!if_a.acc_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) checkOutput("acc_valid_timeout", if_a.acc_valid, 1);
        @(posedge clk);
        #1;
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        acc_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_ready = 1'b0;
    endtask

    task automatic applyStimulus(input int gap_max, input int ready_delay);
        int total = 0;
        wait_idle();
        foreach (prods[i]) total += prods[i];
        sb_q.push_back(model(total));
        start_run();
        for (int i = 0; i < LEN; i++)
            send_product(prods[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        collect_result(ready_delay);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_acc_out"}, if_a.acc_out, 0);
        checkOutput({tag, "_acc_valid"}, if_a.acc_valid, 0);
        checkOutput({tag, "_prod_ready"}, if_a.prod_ready, 0);
        checkOutput({tag, "_busy"}, if_a.busy, 0);
        checkOutput({tag, "_ovf"}, if_a.ovf, 0);
        checkOutput({tag, "_acc_sat10"}, if_s.acc_out, 0);
        checkOutput({tag, "_acc_wrap10"}, if_w.acc_out, 0);
    endtask

    initial begin : stimulus
        int cyc;
        int running;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Full-rate run: latency counted in edges from the one sampling start.
        wait_idle();
        foreach (prods[i]) prods[i] = 225;
        sb_q.push_back(model(1800));
        start = 1'b1; prod_in = 8'd225; prod_valid = 1'b1; acc_ready = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end while (!if_a.acc_valid && cyc < 30);
        checkOutput("t1_latency_edges", cyc, LEN + 1);
        @(posedge clk);
        #1;
        prod_valid = 1'b0; acc_ready = 1'b0;

        // Gapped products 1..8 with a start pulse in the middle of the run.
        wait_idle();
        sb_q.push_back(model(36));
        start_run();
        running = 0;
        for (int i = 0; i < LEN; i++) begin
            if (i == 3) start = 1'b1;
            if (i == LEN - 1) begin
                checkOutput("t3_running_sum", if_a.acc_out, running);
                checkOutput("t3_not_done_yet", if_a.acc_valid, 0);
            end
            send_product(i + 1, 1);
            running += i + 1;
            if (i == 4) start = 1'b0;
        end

        // Result held under backpressure while products keep arriving.
        prod_valid = 1'b1; prod_in = 8'd99;
        repeat (5) begin
            @(negedge clk);
            checkOutput("t4_acc_valid", if_a.acc_valid, 1);
            checkOutput("t4_acc_out", if_a.acc_out, 36);
            checkOutput("t4_prod_ready", if_a.prod_ready, 0);
        end

        // Result handoff and a new start in the same cycle.
        @(posedge clk);
        #1;
        prod_valid = 1'b0; acc_ready = 1'b1; start = 1'b1;
        sb_q.push_back(model(16));
        @(posedge clk);
        #1;
        start = 1'b0; acc_ready = 1'b0;
        checkOutput("t5_busy", if_a.busy, 1);
        checkOutput("t5_prod_ready", if_a.prod_ready, 1);
        checkOutput("t5_acc_valid", if_a.acc_valid, 0);
        checkOutput("t5_acc_out", if_a.acc_out, 0);
        checkOutput("t5_ovf", if_a.ovf, 0);
        for (int i = 0; i < LEN; i++) send_product(2, 0);
        collect_result(1);

        // Asynchronous reset in the middle of a run discards the partial sum.
        wait_idle();
        start_run();
        send_product(7, 0);
        send_product(9, 0);
        send_product(11, 0);
        checkOutput("t6_partial_sum", if_a.acc_out, 27);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        foreach (prods[i]) prods[i] = 3;
        applyStimulus(0, 0);

        // Saturate early, then zeros and a one: sat stays pinned, wrap keeps going.
        prods = '{255, 255, 255, 255, 255, 0, 0, 1};
        applyStimulus(0, 2);

        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < LEN; i++) begin
                if (r % 3 == 0)
                    prods[i] = int'($urandom_range(150, 225));
                else
                    prods[i] = int'($urandom_range(0, 15)) * int'($urandom_range(0, 15));
            end
            applyStimulus(r % 3, int'($urandom_range(0, 3)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        checkOutput("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
